// File: rtl/oup_sm_ulpi_syncmode_rx_pkg.sv
// Shared types and constants for the ULPI synchronous-mode receive machine.
package oup_sm_ulpi_syncmode_rx_p;

  // Receive FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TURN      = 3'd1,
    RECV      = 3'd2,
    REGR_PEND = 3'd3,
    REGR_TURN = 3'd4,
    REGR_DATA = 3'd5
  } rx_states_t;

  // RX CMD byte layout as driven by the PHY.
  typedef struct packed {
    logic [1:0] alt_int;
    logic [1:0] rx_event;
    logic [1:0] vbus_state;
    logic [1:0] linestate;
  } rx_cmd_t;

  localparam logic [1:0] RXEVENT_ACTIVE = 2'b01;
  localparam logic [1:0] RXEVENT_ERROR  = 2'b11;

endpackage

// File: rtl/oup_sm_ulpi_syncmode_rx.sv
// ULPI synchronous-mode receive machine. Follows bus ownership on dir,
// decodes RX CMD bytes, forwards USB receive data and completes register
// reads requested by the TX machine.
//
// The state register names the bus cycle that follows the last sample.
// The turnaround sample itself is taken while still in IDLE/REGR_PEND, so
// TURN is the first real PHY cycle after a plain turnaround, REGR_TURN is
// the cycle that carries register-read data, and REGR_DATA is the cycle
// after the read data (normally the dir-low turnaround back to the link).
module oup_sm_ulpi_syncmode_rx
  import oup_sm_ulpi_syncmode_rx_p::*;
#(
  parameter int unsigned REGR_TIMEOUT = 16
) (
  input  logic       ulpi_clk_i,
  input  logic       rst_ni,
  input  logic [7:0] ulpi_data_i,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  input  logic       rx_regr_assert_i,
  output logic       rx_done_o,
  output logic       rx_abort_o,
  output logic [7:0] phyreg_o,
  output logic       phyreg_valid_o,
  output logic [7:0] rx_cmd_o,
  output logic       rx_cmd_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_data_valid_o,
  input  logic       rx_data_full_i,
  output logic       rx_overflow_o,
  output logic       rx_active_o,
  output logic       rx_error_o
);

  localparam int unsigned CNT_W      = (REGR_TIMEOUT > 0) ? $clog2(REGR_TIMEOUT + 1) : 1;
  localparam bit          TIMEOUT_EN = (REGR_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = (REGR_TIMEOUT > 0) ? CNT_W'(REGR_TIMEOUT - 1) : '0;

  rx_states_t       state_p1, state_nxt;
  logic [CNT_W-1:0] cnt_p1;
  logic             abort_p1, served_p1, done_p1;
  logic             active_p1, error_p1;
  logic [7:0]       rx_cmd_p1, rx_data_p1, phyreg_p1;
  logic             rx_cmd_vld_p1, rx_data_vld_p1, ovf_vld_p1, phyreg_vld_p1;

  // Decode strobes produced by the next-state logic.
  logic    abort_set, phy_take, turn_act, byte_cyc, cnt_clr, cnt_inc;
  logic    timeout_hit, regr_req;
  logic    cmd_take, data_take, ovf_take;
  logic    abort_nxt, served_nxt, active_nxt, error_nxt, done_nxt;
  rx_cmd_t cmd_in;

  assign cmd_in      = rx_cmd_t'(ulpi_data_i);
  assign timeout_hit = TIMEOUT_EN && (cnt_p1 == TO_LAST);
  // A read already served (completed or aborted) is not restarted while TX
  // still holds its request high.
  assign regr_req    = rx_regr_assert_i & ~served_p1;

  // Next-state decode and per-cycle strobes.
  always_comb begin
    state_nxt = state_p1;
    abort_set = 1'b0;
    phy_take  = 1'b0;
    turn_act  = 1'b0;
    byte_cyc  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_p1)
      IDLE: begin
        if (ulpi_dir_i) begin
          if (regr_req) begin
            cnt_clr = 1'b1;
            if (ulpi_nxt_i) begin
              abort_set = 1'b1;
              turn_act  = 1'b1;
              state_nxt = RECV;
            end else begin
              state_nxt = REGR_TURN;
            end
          end else begin
            turn_act  = ulpi_nxt_i;
            state_nxt = TURN;
          end
        end else if (regr_req) begin
          cnt_clr   = 1'b1;
          state_nxt = REGR_PEND;
        end
      end
      TURN, RECV: begin
        if (ulpi_dir_i) begin
          byte_cyc  = 1'b1;
          state_nxt = RECV;
        end else begin
          state_nxt = IDLE;
        end
      end
      REGR_PEND: begin
        if (!rx_regr_assert_i) begin
          // TX gave up: no abort; a simultaneous dir rise is a plain receive.
          turn_act  = ulpi_dir_i & ulpi_nxt_i;
          state_nxt = ulpi_dir_i ? TURN : IDLE;
        end else if (ulpi_dir_i) begin
          if (ulpi_nxt_i) begin
            abort_set = 1'b1;
            turn_act  = 1'b1;
            state_nxt = RECV;
          end else begin
            state_nxt = REGR_TURN;
          end
        end else if (timeout_hit) begin
          abort_set = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc = TIMEOUT_EN;
        end
      end
      REGR_TURN: begin
        if (ulpi_dir_i) begin
          phy_take  = 1'b1;
          state_nxt = REGR_DATA;
        end else begin
          abort_set = 1'b1;
          state_nxt = IDLE;
        end
      end
      REGR_DATA: begin
        if (ulpi_dir_i) begin
          byte_cyc  = 1'b1;
          state_nxt = RECV;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte classification and flag updates for the sampled cycle.
  always_comb begin
    cmd_take   = byte_cyc & ~ulpi_nxt_i;
    data_take  = byte_cyc & ulpi_nxt_i & ~rx_data_full_i;
    ovf_take   = byte_cyc & ulpi_nxt_i & rx_data_full_i;
    abort_nxt  = abort_set | (abort_p1 & rx_regr_assert_i);
    served_nxt = abort_set | phy_take | (served_p1 & rx_regr_assert_i);
    active_nxt = active_p1;
    if (!ulpi_dir_i) begin
      active_nxt = 1'b0;
    end else if (turn_act) begin
      active_nxt = 1'b1;
    end else if (cmd_take) begin
      active_nxt = |(cmd_in.rx_event & RXEVENT_ACTIVE);
    end
    error_nxt = error_p1;
    if (cmd_take && (cmd_in.rx_event == RXEVENT_ERROR)) begin
      error_nxt = 1'b1;
    end else if (active_nxt && !active_p1) begin
      error_nxt = 1'b0;
    end
    done_nxt = (state_nxt == IDLE) & ~abort_nxt;
  end

  // FSM state register and read-timeout counter.
  always_ff @(posedge ulpi_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_p1 <= IDLE;
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (cnt_clr) begin
        cnt_p1 <= '0;
      end else if (cnt_inc) begin
        cnt_p1 <= cnt_p1 + 1'b1;
      end
    end
  end

  // Registered status flags, data outputs and their one-cycle valid pulses.
  always_ff @(posedge ulpi_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      abort_p1       <= 1'b0;
      served_p1      <= 1'b0;
      done_p1        <= 1'b1;
      active_p1      <= 1'b0;
      error_p1       <= 1'b0;
      rx_cmd_p1      <= '0;
      rx_cmd_vld_p1  <= 1'b0;
      rx_data_p1     <= '0;
      rx_data_vld_p1 <= 1'b0;
      ovf_vld_p1     <= 1'b0;
      phyreg_p1      <= '0;
      phyreg_vld_p1  <= 1'b0;
    end else begin
      abort_p1       <= abort_nxt;
      served_p1      <= served_nxt;
      done_p1        <= done_nxt;
      active_p1      <= active_nxt;
      error_p1       <= error_nxt;
      rx_cmd_vld_p1  <= cmd_take;
      rx_data_vld_p1 <= data_take;
      ovf_vld_p1     <= ovf_take;
      phyreg_vld_p1  <= phy_take;
      if (cmd_take) begin
        rx_cmd_p1 <= ulpi_data_i;
      end
      if (data_take) begin
        rx_data_p1 <= ulpi_data_i;
      end
      if (phy_take) begin
        phyreg_p1 <= ulpi_data_i;
      end
    end
  end

  assign rx_done_o       = done_p1;
  assign rx_abort_o      = abort_p1;
  assign phyreg_o        = phyreg_p1;
  assign phyreg_valid_o  = phyreg_vld_p1;
  assign rx_cmd_o        = rx_cmd_p1;
  assign rx_cmd_valid_o  = rx_cmd_vld_p1;
  assign rx_data_o       = rx_data_p1;
  assign rx_data_valid_o = rx_data_vld_p1;
  assign rx_overflow_o   = ovf_vld_p1;
  assign rx_active_o     = active_p1;
  assign rx_error_o      = error_p1;

endmodule
